instr_sequencer: RTL



---
 rtl/sequencer_pkg.sv | 30 +++
 rtl/instr_sequencer_decode.sv | 15 +
 rtl/instr_sequencer.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/sequencer_pkg.sv
// Shared types and instruction-word field positions for the program sequencer.
package sequencer_pkg;

  typedef enum logic [1:0] {
    OP_WRITE = 2'b00,
    OP_EXEC  = 2'b01,
    OP_NEXTL = 2'b10,
    OP_HALT  = 2'b11
  } opcode_t;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam int INSTR_W = 32;
  localparam int OPC_HI  = 31;
  localparam int OPC_LO  = 30;
  localparam int ADDR_HI = 29;
  localparam int ADDR_LO = 16;
  localparam int DATA_HI = 15;
  localparam int DATA_LO = 0;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
  localparam int DATA_W  = DATA_HI - DATA_LO + 1;
  localparam int WCNT_W  = 32;

endpackage

// File: rtl/instr_sequencer_decode.sv
// Combinational split of a program word into opcode, register address and write data.
module instr_decode
  import sequencer_pkg::*;
(
  input  logic [INSTR_W-1:0] i_instr,
  output opcode_t            o_opcode,
  output logic [ADDR_W-1:0]  o_addr,
  output logic [DATA_W-1:0]  o_data
);

  assign o_opcode = opcode_t'(i_instr[OPC_HI:OPC_LO]);
  assign o_addr   = i_instr[ADDR_HI:ADDR_LO];
  assign o_data   = i_instr[DATA_HI:DATA_LO];

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer: fetches instruction words and turns them into register-write,
// execute and layer-advance pulses, stalling on the controller's completion flag.
module instr_sequencer
  import sequencer_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run_program,
  input  logic [PC_W-1:0] pc_max,
  output logic            imem_re,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic            wr_en_drv,
  output logic [13:0]     addr_drv,
  output logic [15:0]     write_data_drv,
  output logic            execute_2,
  output logic            next_layer,
  input  logic            done_executing,
  output logic            busy,
  output logic            finished,
  output logic            timeout_err
);

  localparam logic [WCNT_W-1:0] TIMEOUT_LIM = WCNT_W'(TIMEOUT);

  state_t              r_state;
  logic [PC_W-1:0]     r_pc;
  logic [WCNT_W-1:0]   r_wait_cnt;
  logic                r_imem_re;
  logic [PC_W-1:0]     r_imem_addr;
  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_data;
  logic                r_execute;
  logic                r_next_layer;
  logic                r_timeout_err;

  opcode_t             w_opcode;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic [PC_W-1:0]     w_pc_inc;
  logic                w_pc_end;
  logic [WCNT_W-1:0]   w_wait_cnt_inc;
  logic                w_timeout_hit;
  logic                w_wait_done;
  logic                w_advance;

  instr_decode u_decode (
    .i_instr  (imem_rdata),
    .o_opcode (w_opcode),
    .o_addr   (w_addr),
    .o_data   (w_data)
  );

  assign w_pc_inc       = r_pc + PC_W'(1);
  assign w_pc_end       = (w_pc_inc == pc_max);
  assign w_wait_cnt_inc = (&r_wait_cnt) ? r_wait_cnt : r_wait_cnt + WCNT_W'(1);
  assign w_timeout_hit  = (w_wait_cnt_inc >= TIMEOUT_LIM);
  // The completion flag is not trusted while our own execute pulse is still on the wire.
  assign w_wait_done    = done_executing && !r_execute;
  assign w_advance      = ((r_state == S_DECODE) && ((w_opcode == OP_WRITE) || (w_opcode == OP_NEXTL)))
                       || ((r_state == S_WAIT) && w_wait_done);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_pc          <= '0;
      r_wait_cnt    <= '0;
      r_imem_re     <= 1'b0;
      r_imem_addr   <= '0;
      r_wr_en       <= 1'b0;
      r_addr        <= '0;
      r_data        <= '0;
      r_execute     <= 1'b0;
      r_next_layer  <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_imem_re    <= 1'b0;
      r_wr_en      <= 1'b0;
      r_execute    <= 1'b0;
      r_next_layer <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (run_program) begin
            r_pc          <= '0;
            r_timeout_err <= 1'b0;
            if (pc_max == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state     <= S_FETCH;
              r_imem_re   <= 1'b1;
              r_imem_addr <= '0;
            end
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          unique case (w_opcode)
            OP_WRITE: begin
              r_wr_en <= 1'b1;
              r_addr  <= w_addr;
              r_data  <= w_data;
            end
            OP_NEXTL: r_next_layer <= 1'b1;
            OP_EXEC: begin
              r_execute  <= 1'b1;
              r_wait_cnt <= '0;
              r_state    <= S_WAIT;
            end
            OP_HALT: r_state <= S_DONE;
          endcase
        end
        S_WAIT: begin
          r_wait_cnt <= w_wait_cnt_inc;
          if (!w_wait_done && w_timeout_hit) begin
            r_timeout_err <= 1'b1;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (!run_program) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      // Shared pc step for WRITE, NEXTL and a completed EXEC.
      if (w_advance) begin
        r_pc <= w_pc_inc;
        if (w_pc_end) begin
          r_state <= S_DONE;
        end else begin
          r_state     <= S_FETCH;
          r_imem_re   <= 1'b1;
          r_imem_addr <= w_pc_inc;
        end
      end
    end
  end

  assign imem_re        = r_imem_re;
  assign imem_addr      = r_imem_addr;
  assign wr_en_drv      = r_wr_en;
  assign addr_drv       = r_addr;
  assign write_data_drv = r_data;
  assign execute_2      = r_execute;
  assign next_layer     = r_next_layer;
  assign timeout_err    = r_timeout_err;
  assign busy           = (r_state != S_IDLE) && (r_state != S_DONE);
  assign finished       = (r_state == S_DONE);

endmodule
